// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter and registered 4:1 select datapath with per-grant hold limit
// Optional MUX_ARB_LOCK_EN adds a lock input that suspends hold-limit expiry for the current owner.
module mux_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   din,
`ifdef MUX_ARB_LOCK_EN
  input  logic                  lock,
`endif
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic [DATA_W-1:0]     y,
  output logic                  valid
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [7:0]          hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]   y_q;
  logic                valid_q;

  logic [1:0]          win;
  logic                grant;
  logic                others;
  logic                at_max;
  logic                locked;

  // First requester at or after the search pointer, wrapping mod 4.
  function automatic logic [1:0] arb(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] res;
    res = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant      = 1'b0;
    win        = arb(req, ptr_q);
    others     = |(req & ~(4'b0001 << sel_q));
    at_max     = (hold_cnt_q == 8'(MAX_HOLD));
`ifdef MUX_ARB_LOCK_EN
    locked     = lock & req[sel_q];
`else
    locked     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (|req) grant = 1'b1;
        else      gnt_d = 4'b0000;
      end
      HOLD: begin
        if (!req[sel_q] || (at_max && others && !locked)) begin
          if (|req) begin
            grant = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (at_max) begin
          // Sole requester reloads; a locked owner saturates at the limit.
          if (!locked) hold_cnt_d = 8'd1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d    = HOLD;
      gnt_d      = 4'b0001 << win;
      sel_d      = win;
      ptr_d      = win + 2'd1;
      hold_cnt_d = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 8'd0;
      y_q        <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      y_q        <= din[sel_q*DATA_W +: DATA_W];
      valid_q    <= (state_q == HOLD);
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign y     = y_q;
  assign valid = valid_q;

endmodule
